// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory BRAM (write port A, read port B,
// common address/mask) between the CPU path (m0) and the debug reader (m1).
// Ports: clk, rst (async, active high); per master mN_req/we/addr/mask/wdata
// in, mN_gnt/rvalid/rdata out; BRAM side mem_we/re/addr/mask/wdata out,
// mem_rdata in (1-cycle latency).
// Default: fixed priority (m0 first) with a starvation guard for m1.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead.
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_mask,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_mask,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_mask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic m1_wins;

`ifdef DMEM_ARB_RR_EN
  // 0 = m0 won last, 1 = m1 won last
  logic last_winner;

  assign m1_wins = ~m0_req | ~last_winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner <= 1'b1;
    end else if (m0_gnt | m1_gnt) begin
      last_winner <= m1_gnt;
    end
  end
`else
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;

  // m1 is forced through once it has lost MAX_WAIT cycles in a row
  assign m1_wins = ~m0_req | (starve_cnt == MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (m1_req & ~m1_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`endif

  assign m1_gnt = ~rst & m1_req & m1_wins;
  assign m0_gnt = ~rst & m0_req & ~m1_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_mask  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_re    = ~m0_we;
      mem_addr  = m0_addr;
      mem_mask  = m0_mask;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_re    = ~m1_we;
      mem_addr  = m1_addr;
      mem_mask  = m1_mask;
      mem_wdata = m1_wdata;
    end
  end

  // Tags the read issued this cycle so its data returns to the right master
  logic              rd_vld;
  logic              rd_id;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_id  <= 1'b0;
    end else begin
      rd_vld <= mem_re;
      rd_id  <= m1_gnt;
    end
  end

  assign m0_rvalid = rd_vld & ~rd_id;
  assign m1_rvalid = rd_vld & rd_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (m0_rvalid) hold0 <= mem_rdata;
      if (m1_rvalid) hold1 <= mem_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? mem_rdata : hold0;
  assign m1_rdata = m1_rvalid ? mem_rdata : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
// with a small BRAM model on the memory side.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [4:0]  m0_addr, m1_addr;
  logic [3:0]  m0_mask, m1_mask;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we, mem_re;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bram [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_mask(m0_mask), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_mask(m1_mask), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) bram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_re) mem_rdata <= bram[mem_addr];
  end

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_mask = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_mask = 0; m1_wdata = 0;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    m0_req = 1; m1_req = 1; m0_mask = 4'hf; m1_mask = 4'hf;
    step(); step();
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    end
    n_checks++;
    if ({mem_we, mem_re} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mem_en: got %b expected 00", {mem_we, mem_re});
    end
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    n_checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
    end
    idle();
    rst = 0;
  endtask

  task automatic test_idle_outputs();
    idle();
    m0_addr = 5'd9; m0_wdata = 32'hdeadbeef; m0_mask = 4'hf;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we, mem_re} !== 4'b0 || mem_addr !== 5'd0 ||
        mem_wdata !== 32'h0 || mem_mask !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got gnt=%b%b we=%b re=%b addr=%h wd=%h expected all 0",
               m0_gnt, m1_gnt, mem_we, mem_re, mem_addr, mem_wdata);
    end
    idle();
  endtask

  task automatic test_read_m0();
    step();
    m0_req = 1; m0_addr = 5'd3; m0_mask = 4'hf;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_re, mem_we} !== 4'b1010 || mem_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL read_m0_gnt: got gnt=%b%b re=%b we=%b addr=%0d expected 10 1 0 3",
               m0_gnt, m1_gnt, mem_re, mem_we, mem_addr);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_m0_data: got v=%b d=%h expected 1 12345678", m0_rvalid, m0_rdata);
    end
    n_checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL read_m0_other: got v=%b d=%h expected 0 0", m1_rvalid, m1_rdata);
    end
    step();
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_m0_hold: got v=%b d=%h expected 0 12345678", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_write_then_read();
    m0_req = 1; m0_we = 1; m0_addr = 5'd5; m0_mask = 4'b0011;
    m0_wdata = 32'haabbccdd;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || {mem_we, mem_re} !== 2'b10 || mem_mask !== 4'b0011 ||
        mem_wdata !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL write_issue: got gnt=%b we=%b re=%b mask=%b wd=%h expected 1 1 0 0011 aabbccdd",
               m0_gnt, mem_we, mem_re, mem_mask, mem_wdata);
    end
    step();
    idle();
    m1_req = 1; m1_addr = 5'd5; m1_mask = 4'hf;
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_rvalid: got gnt1=%b rv=%b%b expected 1 00",
               m1_gnt, m0_rvalid, m1_rvalid);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5566ccdd || m0_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_readback: got v=%b d=%h v0=%b expected 1 5566ccdd 0",
               m1_rvalid, m1_rdata, m0_rvalid);
    end
    step();
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_g;
    rst = 1;
    step();
    rst = 0;
    m0_req = 1; m0_addr = 5'd1; m0_mask = 4'hf;
    m1_req = 1; m1_addr = 5'd2; m1_mask = 4'hf;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp_g);
      end
      step();
    end
    idle();
    step();
  endtask
`else
  task automatic test_starvation();
    logic [1:0] exp_g;
    m0_req = 1; m0_addr = 5'd1; m0_mask = 4'hf;
    m1_req = 1; m1_addr = 5'd2; m1_mask = 4'hf;
    // m0 wins 4, m1 on the 5th; counter cleared so pattern repeats
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp_g = (c % 5 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp_g);
      end
      step();
      if (c == 5) begin
        n_checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h22222222) begin
          n_fail++;
          $display("FAIL starve_m1_data: got v=%b d=%h expected 1 22222222",
                   m1_rvalid, m1_rdata);
        end
      end
    end
    idle();
    step();
  endtask
`endif

  task automatic test_back_to_back();
    m0_req = 1; m0_addr = 5'd1; m0_mask = 4'hf;
    #1;
    step();
    idle();
    m1_req = 1; m1_addr = 5'd2; m1_mask = 4'hf;
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h11111111) begin
      n_fail++;
      $display("FAIL b2b_t1: got g1=%b v0=%b d0=%h expected 1 1 11111111",
               m1_gnt, m0_rvalid, m0_rdata);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h22222222) begin
      n_fail++;
      $display("FAIL b2b_t2_m1: got v=%b d=%h expected 1 22222222", m1_rvalid, m1_rdata);
    end
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h11111111) begin
      n_fail++;
      $display("FAIL b2b_t2_m0: got v=%b d=%h expected 0 11111111", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    m1_req = 1; m1_addr = 5'd3; m1_mask = 4'hf;
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", m1_gnt);
    end
    step();
    rst = 1;
    m0_req = 1; m0_mask = 4'hf;
    #1;
    n_checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got v=%b d=%h expected 0 0", m1_rvalid, m1_rdata);
    end
    step();
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we, mem_re} !== 4'b0 || m0_rvalid !== 1'b0 ||
        m0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_held: got gnt=%b%b we=%b re=%b v0=%b d0=%h expected all 0",
               m0_gnt, m1_gnt, mem_we, mem_re, m0_rvalid, m0_rdata);
    end
    idle();
    rst = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bram[i] = 32'h0;
    bram[1] = 32'h11111111;
    bram[2] = 32'h22222222;
    bram[3] = 32'h12345678;
    bram[5] = 32'h55667788;
    mem_rdata = 32'h0;
    test_reset();
    test_idle_outputs();
    test_read_m0();
    test_write_then_read();
`ifdef DMEM_ARB_RR_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
